mpc_div_30s_8ns_21_seq: RTL
===========================

# mpc_div_30s_8ns_21_seq

Sequential signed-by-unsigned divider for the MPC datapath: the inverse of the 21s × 8ns → 30 pipelined multiplier. It divides a 30-bit signed product-domain value by an 8-bit unsigned scale factor and returns a 21-bit signed saturated quotient plus a remainder, one quotient bit per cycle. It sits wherever the controller must undo a fixed-point scaling: weight normalisation and rescaling the accumulator back to state width.

## Interface
- No parameters; widths fixed at 30 (dividend), 8 (divisor), 21 (quotient), 9 (remainder).
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; when 0 every register holds
- start  in  1  request; sampled only when ready=1 and ce=1
- a  in  30  dividend, signed two's complement
- b  in  8  divisor, unsigned
- ready  out  1  high in IDLE; start accepted
- done  out  1  one-ce-cycle pulse; q/r/sat/div0 valid
- q  out  21  signed quotient, truncated toward zero, saturated
- r  out  9  signed remainder; sign follows a; |r| < b
- sat  out  1  quotient clipped to 21-bit range
- div0  out  1  b was zero

## Operation
- Reset values: ready=1, done=0, q=0, r=0, sat=0, div0=0; state IDLE.
- IDLE:
  - On start (ce=1), register |a| (30-bit unsigned, −2^29 → 2^29), b, sign(a) and div0=(b==0).
  - Clear the partial remainder, load bit counter=29, go to CALC.
- CALC: restoring radix-2 step per ce-cycle.
  - Partial remainder (9 bits) = {rem, next dividend MSB}; if ≥ b, subtract and shift quotient bit 1, else shift 0.
  - 30 iterations; counter 0 → FIX.
- FIX: one cycle, registers the outputs and pulses done, then → IDLE.
  - Quotient magnitude m (30 bits) gets sign(a) applied.
  - If positive and m > 2^20−1: q=2^20−1, sat=1.
  - If negative and m > 2^20: q=−2^20, sat=1.
  - Otherwise q=±m, sat=0.
  - r = remainder with sign(a); 0 when zero.
- Divide-by-zero: full iteration still runs (constant latency).
  - q=2^20−1 if a≥0, else −2^20.
  - r=0, sat=1, div0=1.
- q/r/sat/div0 hold their values until the next FIX. done is high only in the FIX-result cycle.
- Remainder is exact even when q saturates.

## Timing
- Start accepted at edge E0. CALC occupies edges E1..E30. Outputs and done=1 appear after edge E31: latency 31 ce-cycles.
- ready deasserts after E0 and reasserts with done. A start in the done cycle is accepted (back-to-back, 31-cycle throughput).
- start while ready=0 is ignored; no queueing.
- a and b are captured only at E0 and may change afterwards.
- ce=0 freezes state, counter and outputs, including a high done, which stays high until the next ce=1 edge. Latency is counted in ce=1 edges.
- rst during CALC or FIX aborts the operation.
  - Next cycle: IDLE, ready=1, outputs at reset values.
  - No done is issued for the aborted request.
- rst has priority over ce and start.

## Test plan
- a=1000, b=7, ce=1 → done exactly 31 cycles after start; q=142, r=6, sat=0, div0=0; ready low for cycles 1..30.
- a=−1000, b=7 → q=−142, r=−6. a=−3, b=5 → q=0, r=−3.
- Saturation:
  - a=536870911, b=1 → q=1048575, r=0, sat=1.
  - a=−536870912, b=255 → q=−1048576, r=−32, sat=1.
- Divide-by-zero:
  - a=−5, b=0 → q=−1048576, r=0, sat=1, div0=1, latency 31.
  - a=0, b=0 → q=1048575, div0=1.
- Clock enable and handshake: a=1000, b=7, ce low for 5 cycles mid-CALC → done 36 cycles after start, same result. A start pulse while busy (a=1, b=1) has no effect. A start in the done cycle (a=255, b=255) gives q=1, r=0, 31 cycles later.
- rst asserted 10 cycles into CALC → next cycle ready=1, q=0, r=0, done never pulses. A following start with a=100, b=10 gives q=10, r=0.

Source files
------------

// File: rtl/mpc_div_30s_8ns_21_seq.sv
// Sequential 30s / 8ns restoring divider: one quotient bit per ce-cycle,
// 21-bit signed saturated quotient plus remainder signed like the dividend.
module mpc_div_30s_8ns_21_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        start,
  input  logic [29:0] a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        done,
  output logic [20:0] q,
  output logic [8:0]  r,
  output logic        sat,
  output logic        div0
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [29:0] dvd_q, dvd_d;
  logic [29:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  b_q, b_d;
  logic        neg_q, neg_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [20:0] q_q, q_d;
  logic [8:0]  r_q, r_d;
  logic        sat_q, sat_d;
  logic        div0_q, div0_d;

  logic [8:0]  partial_s;
  logic        ge_s;

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    b_d       = b_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    q_d       = q_q;
    r_d       = r_q;
    sat_d     = sat_q;
    div0_d    = div0_q;
    partial_s = {rem_q, dvd_q[29]};
    ge_s      = (partial_s >= {1'b0, b_q});

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = a[29] ? (30'd0 - a) : a;
          b_d     = b;
          neg_d   = a[29];
          zero_d  = (b == 8'd0);
          rem_d   = 8'd0;
          quo_d   = 30'd0;
          cnt_d   = 5'd29;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Result of a successful subtract is < b, so 8 bits suffice.
        rem_d = ge_s ? (partial_s[7:0] - b_q) : partial_s[7:0];
        quo_d = {quo_q[28:0], ge_s};
        dvd_d = {dvd_q[28:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        done_d  = 1'b1;
        div0_d  = zero_q;
        state_d = ST_IDLE;
        if (zero_q) begin
          q_d   = neg_q ? 21'h100000 : 21'h0FFFFF;
          r_d   = 9'd0;
          sat_d = 1'b1;
        end else begin
          r_d = neg_q ? (9'd0 - {1'b0, rem_q}) : {1'b0, rem_q};
          if (neg_q) begin
            if (quo_q > 30'd1048576) begin
              q_d   = 21'h100000;
              sat_d = 1'b1;
            end else begin
              q_d   = 21'd0 - quo_q[20:0];
              sat_d = 1'b0;
            end
          end else begin
            if (quo_q > 30'd1048575) begin
              q_d   = 21'h0FFFFF;
              sat_d = 1'b1;
            end else begin
              q_d   = quo_q[20:0];
              sat_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rst wins over ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 30'd0;
      quo_q   <= 30'd0;
      rem_q   <= 8'd0;
      b_q     <= 8'd0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= 21'd0;
      r_q     <= 9'd0;
      sat_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      sat_q   <= sat_d;
      div0_q  <= div0_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign q     = q_q;
  assign r     = r_q;
  assign sat   = sat_q;
  assign div0  = div0_q;

endmodule
